stage1if: RTL and testbench

Instruction fetch stage: the producer side of the decode stage's `pc_in`/`instr_in`/`enable_in`/`stall_in` interface. It owns the program counter and issues word addresses to a synchronous instruction memory. It presents each fetched 24-bit instruction together with its PC, and honours the hazard unit's stall and the execute stage's branch redirect. Squashed or empty slots are emitted as NOP (24'h000000).

---
 rtl/stage1if_if.sv | 58 +++++
 rtl/stage1if.sv | 187 ++++++++++++++++++
 tb/tb_stage1if.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage1if_if.sv
// ---------------------------------------------------------------------------
// stage1if_if
//   Signal bundle for the instruction fetch stage. Gathers the pipeline
//   control inputs, the instruction memory read port and the decode-facing
//   outputs behind one interface. clk/rst stay plain ports on the module.
//
//   master : the fetch stage itself (stage1if)
//   slave  : its environment (hazard unit, execute stage, imem, decode)
//
//   enable_in        pipeline enable (low behaves as a stall)
//   enable_out       combinational copy of enable_in
//   stall_in         hazard stall
//   branch_taken_in  redirect request
//   branch_pc_in     redirect target
//   imem_rd_out      instruction memory read strobe
//   imem_addr_out    instruction memory word address
//   imem_data_in     instruction memory read data (one cycle after strobe)
//   pc_out           PC of instr_out
//   instr_out        fetched instruction, 24'h0 for a bubble
// ---------------------------------------------------------------------------
interface stage1if_if;
    logic        enable_in;
    logic        enable_out;
    logic        stall_in;
    logic        branch_taken_in;
    logic [23:0] branch_pc_in;
    logic        imem_rd_out;
    logic [23:0] imem_addr_out;
    logic [23:0] imem_data_in;
    logic [23:0] pc_out;
    logic [23:0] instr_out;

    modport master (
        input  enable_in,
        input  stall_in,
        input  branch_taken_in,
        input  branch_pc_in,
        input  imem_data_in,
        output enable_out,
        output imem_rd_out,
        output imem_addr_out,
        output pc_out,
        output instr_out
    );

    modport slave (
        output enable_in,
        output stall_in,
        output branch_taken_in,
        output branch_pc_in,
        output imem_data_in,
        input  enable_out,
        input  imem_rd_out,
        input  imem_addr_out,
        input  pc_out,
        input  instr_out
    );
endinterface

// File: rtl/stage1if.sv
// ---------------------------------------------------------------------------
// stage1if
//   Instruction fetch stage. Owns the program counter, issues word reads to a
//   synchronous instruction memory (data returns the cycle after the strobe)
//   and presents {pc, instr} to decode two cycles after the address issue.
//   Per cycle priority: branch redirect > hold (stall or !enable) > run.
//   Squashed or empty slots are emitted as instr 24'h000000.
//
//   Parameter:
//     RESET_PC   first address fetched after reset
//   Ports:
//     clk        clock, rising edge
//     rst        asynchronous active-high reset
//     bus        stage1if_if.master (control, imem port, decode outputs)
//
//   Build option:
//     STAGE1IF_SKID_EN  defined   : a hold captures the in-flight instruction
//                                   into a one-entry skid; no bubble on release.
//                       undefined : a hold discards the in-flight instruction
//                                   and rewinds fetch_pc; one NOP on release.
// ---------------------------------------------------------------------------
module stage1if #(
    parameter logic [23:0] RESET_PC = 24'h000000
) (
    input  logic      clk,
    input  logic      rst,
    stage1if_if.master bus
);

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_HOLD,
        ACT_BRANCH
    } action_t;

    action_t     action;
    logic        hold;

    logic [23:0] fetch_pc;
    logic [23:0] req_pc;
    logic        req_valid;
    logic [23:0] pc_latch;
    logic [23:0] instr_latch;

    // Output latch load value for a run cycle
    logic [23:0] load_pc;
    logic [23:0] load_instr;

`ifdef STAGE1IF_SKID_EN
    logic        skid_valid;
    logic [23:0] skid_pc;
    logic [23:0] skid_instr;
`endif

    // -----------------------------------------------------------------------
    // Cycle classification
    // -----------------------------------------------------------------------
    always_comb begin
        hold = bus.stall_in | ~bus.enable_in;
    end

    always_comb begin
        action = ACT_RUN;
        if (bus.branch_taken_in) begin
            action = ACT_BRANCH;
        end else if (hold) begin
            action = ACT_HOLD;
        end
    end

    // -----------------------------------------------------------------------
    // Run-cycle output selection: skid entry first, then the returning read,
    // otherwise a bubble tagged with the last requested PC.
    // -----------------------------------------------------------------------
    always_comb begin
        load_pc    = req_pc;
        load_instr = '0;
`ifdef STAGE1IF_SKID_EN
        if (skid_valid) begin
            load_pc    = skid_pc;
            load_instr = skid_instr;
        end else if (req_valid) begin
            load_instr = bus.imem_data_in;
        end
`else
        if (req_valid) begin
            load_instr = bus.imem_data_in;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.enable_out    = bus.enable_in;
    assign bus.imem_rd_out   = (action == ACT_RUN) & ~rst;
    assign bus.imem_addr_out = fetch_pc;
    assign bus.pc_out        = pc_latch;
    assign bus.instr_out     = instr_latch;

    // -----------------------------------------------------------------------
    // Fetch address and outstanding request
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            req_valid <= 1'b0;
        end else begin
            unique case (action)
                ACT_BRANCH: begin
                    fetch_pc  <= bus.branch_pc_in;
                    req_valid <= 1'b0;
                end
                ACT_HOLD: begin
                    if (req_valid) begin
`ifndef STAGE1IF_SKID_EN
                        // Data is dropped; rewind so the same word is re-read
                        fetch_pc <= req_pc;
`endif
                        req_valid <= 1'b0;
                    end
                end
                default: begin
                    fetch_pc  <= fetch_pc + 24'd1;
                    req_pc    <= fetch_pc;
                    req_valid <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output latches
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_latch    <= '0;
            instr_latch <= '0;
        end else begin
            unique case (action)
                ACT_BRANCH: begin
                    instr_latch <= '0;
                end
                ACT_HOLD: begin
                    pc_latch    <= pc_latch;
                    instr_latch <= instr_latch;
                end
                default: begin
                    pc_latch    <= load_pc;
                    instr_latch <= load_instr;
                end
            endcase
        end
    end

`ifdef STAGE1IF_SKID_EN
    // -----------------------------------------------------------------------
    // Skid entry: filled by a hold that finds a read returning, drained by
    // the next run cycle, dropped by a branch.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            unique case (action)
                ACT_BRANCH: begin
                    skid_valid <= 1'b0;
                end
                ACT_HOLD: begin
                    if (req_valid) begin
                        skid_valid <= 1'b1;
                        skid_pc    <= req_pc;
                        skid_instr <= bus.imem_data_in;
                    end
                end
                default: begin
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_stage1if.sv
module tb_stage1if;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stage1if_if bus ();
    stage1if_if wbus ();

    stage1if #(.RESET_PC(24'h000010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    stage1if #(.RESET_PC(24'hFFFFFE)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    // Synchronous instruction memories: word[a] = a + 24'h100000
    always @(posedge clk) begin
        if (bus.imem_rd_out)  bus.imem_data_in  <= bus.imem_addr_out + 24'h100000;
        if (wbus.imem_rd_out) wbus.imem_data_in <= wbus.imem_addr_out + 24'h100000;
    end

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: program-order view of the fetch stream.
    // pend holds PCs already requested but not yet delivered to decode.
    logic [23:0] m_next;
    logic [23:0] m_last;
    logic [23:0] m_pc;
    logic [23:0] m_instr;
    logic [23:0] pend [$];
    bit          skid_mode;

    logic [23:0] wrap_exp [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    int unsigned wrap_idx = 0;

    function automatic logic [23:0] word(input logic [23:0] a);
        return a + 24'h100000;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next  = 24'h000010;
        m_last  = '0;
        m_pc    = '0;
        m_instr = '0;
        pend.delete();
    endtask

    task automatic model_step(input bit st, input bit en, input bit br, input logic [23:0] bpc);
        if (br) begin
            pend.delete();
            m_next  = bpc;
            m_instr = '0;
        end else if (st || !en) begin
            if (!skid_mode && pend.size() > 0) begin
                m_next = pend[0];
                pend.delete();
            end
        end else begin
            if (pend.size() > 0) begin
                m_pc    = pend.pop_front();
                m_instr = word(m_pc);
            end else begin
                m_pc    = m_last;
                m_instr = '0;
            end
            pend.push_back(m_next);
            m_last = m_next;
            m_next = m_next + 24'd1;
        end
    endtask

    // One clock cycle, entered and left just after a falling edge
    task automatic step(input bit st, input bit en, input bit br, input logic [23:0] bpc);
        bus.stall_in        = st;
        bus.enable_in       = en;
        bus.branch_taken_in = br;
        bus.branch_pc_in    = bpc;
        #1;
        chk("imem_rd", {23'd0, bus.imem_rd_out}, {23'd0, (!br && !st && en)});
        chk("imem_addr", bus.imem_addr_out, m_next);
        chk("enable_out", {23'd0, bus.enable_out}, {23'd0, en});
        if (wrap_idx < 4) begin
            chk("wrap_addr", wbus.imem_addr_out, wrap_exp[wrap_idx]);
            wrap_idx++;
        end
        @(posedge clk);
        model_step(st, en, br, bpc);
        #1;
        chk("pc_out", bus.pc_out, m_pc);
        chk("instr_out", bus.instr_out, m_instr);
        @(negedge clk);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pc", bus.pc_out, 24'h0);
        chk("rst_instr", bus.instr_out, 24'h0);
        chk("rst_rd", {23'd0, bus.imem_rd_out}, 24'h0);
        chk("rst_addr", bus.imem_addr_out, 24'h000010);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
`ifdef STAGE1IF_SKID_EN
        skid_mode = 1'b1;
`else
        skid_mode = 1'b0;
`endif
        rst                  = 1'b1;
        bus.stall_in         = 1'b0;
        bus.enable_in        = 1'b1;
        bus.branch_taken_in  = 1'b0;
        bus.branch_pc_in     = '0;
        wbus.stall_in        = 1'b0;
        wbus.enable_in       = 1'b1;
        wbus.branch_taken_in = 1'b0;
        wbus.branch_pc_in    = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("reset_pc", bus.pc_out, 24'h0);
        chk("reset_instr", bus.instr_out, 24'h0);
        chk("reset_rd", {23'd0, bus.imem_rd_out}, 24'h0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch: first instruction two cycles after its strobe
        run(2);
        chk("first_pc", bus.pc_out, 24'h000010);
        chk("first_instr", bus.instr_out, 24'h100010);
        run(2);
        chk("pre_branch_pc", bus.pc_out, 24'h000012);

        // Branch to 0x40: two bubbles, then the target stream
        step(1'b0, 1'b1, 1'b1, 24'h000040);
        chk("br_bubble1", bus.instr_out, 24'h0);
        run(1);
        chk("br_bubble2", bus.instr_out, 24'h0);
        run(1);
        chk("br_tgt_pc", bus.pc_out, 24'h000040);
        chk("br_tgt_instr", bus.instr_out, 24'h100040);
        run(1);
        chk("br_tgt1_pc", bus.pc_out, 24'h000041);

        // Mid-stream async reset, then a 3-cycle stall at pc_out = 0x13
        do_reset();
        run(5);
        chk("stall_start_pc", bus.pc_out, 24'h000013);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 24'h0);
            chk("stall_hold_pc", bus.pc_out, 24'h000013);
            chk("stall_hold_instr", bus.instr_out, 24'h100013);
        end
        if (!skid_mode) begin
            run(1);
            chk("replay_nop", bus.instr_out, 24'h0);
        end
        run(1);
        chk("release_instr0", bus.instr_out, 24'h100014);
        run(1);
        chk("release_instr1", bus.instr_out, 24'h100015);

        // Branch during a stall wins and drops any captured entry
        step(1'b1, 1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b1, 1'b1, 24'h000080);
        step(1'b1, 1'b1, 1'b0, 24'h0);
        run(1);
        chk("stall_br_bubble", bus.instr_out, 24'h0);
        run(1);
        chk("stall_br_pc", bus.pc_out, 24'h000080);
        chk("stall_br_instr", bus.instr_out, 24'h100080);

        // Enable low for two cycles behaves as a stall
        step(1'b0, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        run(3);

        // Back-to-back branches: last one wins
        step(1'b0, 1'b1, 1'b1, 24'h000100);
        step(1'b0, 1'b1, 1'b1, 24'h000200);
        run(2);
        chk("b2b_pc", bus.pc_out, 24'h000200);

        // Randomized traffic against the model
        for (int unsigned i = 0; i < 400; i++) begin
            int unsigned r;
            bit          st, en, br;
            logic [23:0] bpc;
            if (i == 200) do_reset();
            r   = $urandom_range(0, 99);
            br  = (r < 8);
            st  = (r >= 8 && r < 28) || ($urandom_range(0, 9) == 0);
            en  = !(r >= 28 && r < 38);
            bpc = ($urandom_range(0, 3) == 0) ? (24'hFFFFFC + 24'($urandom_range(0, 3)))
                                               : 24'($urandom_range(0, 255));
            step(st, en, br, bpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
